// File: rtl/pipeline_hazard_ctrl.sv
// Scoreboard-based RAW hazard and redirect flush controller for a 5-stage
// in-order pipeline without forwarding. Each architectural register (x1..)
// has a countdown of cycles until its pending write becomes readable in D.
// Optional build macro: HAZARD_PERF_CNT_EN adds stall/flush perf counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned WB_LATENCY = 3,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dec_valid,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic                dec_uses_rs1,
  input  logic                dec_uses_rs2,
  input  logic [4:0]          dec_rd,
  input  logic                dec_rwe,
  input  logic                ex_redirect,
  output logic                pc_hold,
  output logic                fd_flush,
  output logic                dx_bubble,
  output logic                issue,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_events
`endif
);

  localparam int unsigned CNT_W = $clog2(WB_LATENCY + 1);
  localparam int unsigned REG_W = 5;

  logic [CNT_W-1:0] cnt [1:NUM_REGS-1];
  logic             hazard;
  logic             sb_load;

  // Pending-write flags; x0 is hardwired and never tracked.
  always_comb begin
    busy_vec    = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // RAW detection and pipeline control; a redirect overrides a stall.
  always_comb begin
    hazard    = dec_valid &
                ((dec_uses_rs1 & (dec_rs1 != '0) & busy_vec[dec_rs1]) |
                 (dec_uses_rs2 & (dec_rs2 != '0) & busy_vec[dec_rs2]));
    issue     = dec_valid & ~hazard & ~ex_redirect;
    pc_hold   = hazard & ~ex_redirect;
    fd_flush  = ex_redirect;
    dx_bubble = hazard | ex_redirect;
    sb_load   = issue & dec_rwe & (dec_rd != '0);
  end

  // Countdown per register: an issuing writer reloads, others drain to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (sb_load && (dec_rd == REG_W'(r))) begin
          cnt[r] <= CNT_W'(WB_LATENCY);
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_W'(1);
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running wrap-around counters of stall cycles and redirect events.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_hold) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (ex_redirect) begin
        flush_events <= flush_events + 32'd1;
      end
    end
  end
`endif

endmodule
